// File: rtl/btn_dir_request.sv
// Push-button conditioning: two-flop synchroniser and debouncer per button,
// then a one-hot direction request (valid/ack) and the currently held direction.
module btn_dir_request #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rbtn,
  input  logic       lbtn,
  input  logic       ubtn,
  input  logic       dbtn,
  input  logic       freeze,
  input  logic       dir_req_ack,
  output logic [3:0] dir_req,
  output logic       dir_req_valid,
  output logic [3:0] held_dir,
  output logic [3:0] btn_db
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       db;
  logic [3:0]       db_next;
  logic [3:0]       rise;
  logic [CNT_W-1:0] cnt      [4];
  logic [CNT_W-1:0] cnt_next [4];

  // Bit order matches btn_db and the one-hot codes; bit 0 has highest priority.
  function automatic logic [3:0] pick(input logic [3:0] v);
    if (v[0])      return 4'b0001;
    else if (v[1]) return 4'b0010;
    else if (v[2]) return 4'b0100;
    else if (v[3]) return 4'b1000;
    else           return 4'b0000;
  endfunction

  assign raw    = {dbtn, ubtn, lbtn, rbtn};
  assign btn_db = db;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 4'b0000;
      s2 <= 4'b0000;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_next = db;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = cnt[i];
      if (s2[i] == db[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        db_next[i]  = s2[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
    rise = db_next & ~db;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      db <= db_next;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_next[i];
    end
  end

  // A fresh press beats a same-cycle ack; freeze drops presses but keeps dir_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_req       <= 4'b0000;
      dir_req_valid <= 1'b0;
    end else if (freeze) begin
      dir_req_valid <= 1'b0;
    end else if (|rise) begin
      dir_req       <= pick(rise);
      dir_req_valid <= 1'b1;
    end else if (dir_req_ack && dir_req_valid) begin
      dir_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || freeze) held_dir <= 4'b0000;
    else               held_dir <= pick(db);
  end

endmodule

// File: tb/tb_btn_dir_request.sv
// Self-checking bench for btn_dir_request: constant vector table, directed
// corner sequences and randomized stimulus against a behavioural model.
module tb_btn_dir_request;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       rbtn, lbtn, ubtn, dbtn;
  logic       freeze;
  logic       dir_req_ack;
  logic [3:0] dir_req;
  logic       dir_req_valid;
  logic [3:0] held_dir;
  logic [3:0] btn_db;

  int vectors;
  int miscompares;

  btn_dir_request #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .rbtn(rbtn), .lbtn(lbtn), .ubtn(ubtn), .dbtn(dbtn),
    .freeze(freeze), .dir_req_ack(dir_req_ack),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .held_dir(held_dir), .btn_db(btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       frz;
    logic       ack;
    logic       valid;
    logic [3:0] req;
    logic [3:0] held;
    logic [3:0] db;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: raw history, run length of disagreeing samples per button.
  logic [3:0] hist[$];
  logic [3:0] m_db;
  int         m_run[4];
  logic [3:0] m_req;
  logic       m_valid;
  logic [3:0] m_held;

  function automatic logic [3:0] first_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  task automatic modelEdge(input logic r, input logic [3:0] b, input logic f, input logic a);
    logic [3:0] s2v;
    logic [3:0] new_db;
    logic [3:0] rose;
    if (r) begin
      hist = '{4'b0000, 4'b0000};
      m_db = 4'b0000;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_req = 4'b0000;
      m_valid = 1'b0;
      m_held = 4'b0000;
      return;
    end
    s2v = hist[1];
    new_db = m_db;
    for (int i = 0; i < 4; i++) begin
      if (s2v[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          new_db[i] = s2v[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    rose = new_db & ~m_db;
    m_held = f ? 4'b0000 : first_set(m_db);
    if (f) m_valid = 1'b0;
    else if (rose != 4'b0000) begin
      m_req = first_set(rose);
      m_valid = 1'b1;
    end else if (a && m_valid) m_valid = 1'b0;
    m_db = new_db;
    hist.push_front(b);
    hist.pop_back();
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] b, input logic f, input logic a);
    rst = r;
    {dbtn, ubtn, lbtn, rbtn} = b;
    freeze = f;
    dir_req_ack = a;
    @(posedge clk);
    modelEdge(r, b, f, a);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [3:0] er,
                             input logic [3:0] eh, input logic [3:0] ed);
    vectors++;
    if (dir_req_valid !== ev || dir_req !== er || held_dir !== eh || btn_db !== ed) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid=%0b req=%b held=%b db=%b, expected valid=%0b req=%b held=%b db=%b",
               name, dir_req_valid, dir_req, held_dir, btn_db, ev, er, eh, ed);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_valid, m_req, m_held, m_db);
  endtask

  task automatic stepModel(input string name, input logic [3:0] b, input logic f,
                           input logic a, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, b, f, a);
      checkModel(name);
    end
  endtask

  task automatic addVec(input logic r, input logic [3:0] b, input logic f, input logic a,
                        input logic v, input logic [3:0] q, input logic [3:0] h, input logic [3:0] d);
    vec_t t;
    t.rst = r; t.btn = b; t.frz = f; t.ack = a;
    t.valid = v; t.req = q; t.held = h; t.db = d;
    tbl.push_back(t);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    hist = '{4'b0000, 4'b0000};
    m_db = 4'b0000; m_req = 4'b0000; m_valid = 1'b0; m_held = 4'b0000;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    rst = 1'b1; {dbtn, ubtn, lbtn, rbtn} = 4'b0000; freeze = 1'b0; dir_req_ack = 1'b0;

    // Reset with rbtn held, then fresh press after deassert, ack, release.
    for (int i = 0; i < 4; i++) addVec(1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) addVec(0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
    addVec(0, 4'b0001, 0, 0, 1, 4'b0001, 4'b0000, 4'b0001);
    addVec(0, 4'b0001, 0, 0, 1, 4'b0001, 4'b0001, 4'b0001);
    addVec(0, 4'b0001, 0, 1, 0, 4'b0001, 4'b0001, 4'b0001);
    for (int i = 0; i < 5; i++) addVec(0, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001);
    addVec(0, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000);
    addVec(0, 4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    // Clean ubtn press, ack, and continued hold without new request.
    for (int i = 0; i < 5; i++) addVec(0, 4'b0100, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000);
    addVec(0, 4'b0100, 0, 0, 1, 4'b0100, 4'b0000, 4'b0100);
    addVec(0, 4'b0100, 0, 0, 1, 4'b0100, 4'b0100, 4'b0100);
    addVec(0, 4'b0100, 0, 1, 0, 4'b0100, 4'b0100, 4'b0100);
    addVec(0, 4'b0100, 0, 0, 0, 4'b0100, 4'b0100, 4'b0100);
    addVec(0, 4'b0100, 0, 1, 0, 4'b0100, 4'b0100, 4'b0100);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].btn, tbl[i].frz, tbl[i].ack);
      checkOutput($sformatf("table[%0d]", i), tbl[i].valid, tbl[i].req, tbl[i].held, tbl[i].db);
    end
    stepModel("release_u", 4'b0000, 0, 0, 8);

    // Bouncing lbtn: only the final stable run may produce a request.
    stepModel("bounce1", 4'b0010, 0, 0, 1);
    stepModel("bounce0", 4'b0000, 0, 0, 1);
    stepModel("bounce1", 4'b0010, 0, 0, 1);
    stepModel("bounce0", 4'b0000, 0, 0, 1);
    stepModel("bounce_settle", 4'b0010, 0, 0, 5);
    applyStimulus(0, 4'b0010, 0, 0);
    checkOutput("bounce_req", 1, 4'b0010, 4'b0000, 4'b0010);
    stepModel("bounce_ack", 4'b0010, 0, 1, 1);
    stepModel("release_l", 4'b0000, 0, 0, 8);

    // Simultaneous right+down: right wins; releasing right exposes down as held.
    stepModel("simul", 4'b1001, 0, 0, 5);
    applyStimulus(0, 4'b1001, 0, 0);
    checkOutput("simul_req", 1, 4'b0001, 4'b0000, 4'b1001);
    applyStimulus(0, 4'b1001, 0, 1);
    checkOutput("simul_held", 0, 4'b0001, 4'b0001, 4'b1001);
    stepModel("simul_rel", 4'b1000, 0, 0, 6);
    applyStimulus(0, 4'b1000, 0, 0);
    checkOutput("simul_held_d", 0, 4'b0001, 4'b1000, 4'b1000);
    stepModel("release_d", 4'b0000, 0, 0, 8);

    // Pending up request overwritten by left press on the same edge as an ack.
    stepModel("race_u", 4'b0100, 0, 0, 6);
    stepModel("race_l", 4'b0110, 0, 0, 5);
    applyStimulus(0, 4'b0110, 0, 1);
    checkOutput("race_overwrite", 1, 4'b0010, 4'b0100, 4'b0110);
    stepModel("race_ack", 4'b0110, 0, 1, 1);
    stepModel("release_ul", 4'b0000, 0, 0, 8);

    // Press during freeze is lost; only a release and re-press produces a request.
    stepModel("freeze_d", 4'b1000, 1, 0, 7);
    applyStimulus(0, 4'b1000, 1, 0);
    checkOutput("freeze_block", 0, 4'b0010, 4'b0000, 4'b1000);
    stepModel("unfreeze", 4'b1000, 0, 0, 1);
    applyStimulus(0, 4'b1000, 0, 0);
    checkOutput("unfreeze_held", 0, 4'b0010, 4'b1000, 4'b1000);
    stepModel("freeze_rel", 4'b0000, 0, 0, 8);
    stepModel("repress", 4'b1000, 0, 0, 5);
    applyStimulus(0, 4'b1000, 0, 0);
    checkOutput("repress_req", 1, 4'b1000, 4'b0000, 4'b1000);

    // Randomized traffic with bounces, freeze windows, acks and rare resets.
    begin
      logic [3:0] b;
      logic f;
      b = 4'b1000;
      f = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
        if ($urandom_range(0, 39) == 0) f = ~f;
        applyStimulus(($urandom_range(0, 399) == 0), b, f, ($urandom_range(0, 3) == 0));
        checkModel("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_dir_request.md
Name: btn_dir_request

Overview:
- Input-conditioning stage directly upstream of the game-logic top.
- Takes the four raw board push-buttons (rbtn/lbtn/ubtn/dbtn) and synchronises and debounces each one.
- Converts debounced presses into a one-hot direction request with a valid/ack handshake for the pacman movement logic.
- Also exports the currently held direction (level) so game logic can re-try a blocked turn each tile.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced button changes state. Minimum 2. The board build overrides it to 1_000_000.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rbtn  in  1  raw right button, asynchronous to clk, active-high.
- lbtn  in  1  raw left button, same properties.
- ubtn  in  1  raw up button, same properties.
- dbtn  in  1  raw down button, same properties.
- freeze  in  1  high while pacman_is_dead or a level transition is in progress; blocks request generation.
- dir_req_ack  in  1  single-cycle pulse from game logic consuming the pending request.
- dir_req  out  4  one-hot requested direction: right 0001, left 0010, up 0100, down 1000.
- dir_req_valid  out  1  a request is pending.
- held_dir  out  4  one-hot of the highest-priority currently debounced-high button; 0000 if none.
- btn_db  out  4  debounced button levels {dbtn,ubtn,lbtn,rbtn}, for debug and LEDs.

Behaviour:
- Reset (rst=1 at a clk edge): all sync flops, debounced levels and counters are 0. Outputs: dir_req=0000, dir_req_valid=0, held_dir=0000, btn_db=0000.
  - Reset mid-debounce discards partial counts.
  - A button held through reset is treated as a fresh press once rst deasserts: it produces a request after DEBOUNCE_CYCLES+2 edges.
- Synchroniser: two flops per button, s1 then s2. The raw value is visible at s2 two edges after it is sampled.
- Debouncer, per button, with counter cnt and level db:
  - s2==db: cnt<=0.
  - s2!=db and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s2!=db and cnt==DEBOUNCE_CYCLES-1: db<=s2, cnt<=0.
  - Any single-cycle glitch back to db restarts the count.
- Latency: a raw level stable from before edge 0 changes db, and sets dir_req_valid on a press, at edge DEBOUNCE_CYCLES+2 (edge 6 with the default).
- Press event: the edge where db goes 0->1. Release events never create requests.
- Priority for simultaneous press events in one edge: right > left > up > down. Only the winner is latched; losers are dropped.
- Request register at each edge, in priority order:
  1. rst.
  2. freeze=1: dir_req_valid<=0, dir_req held. Press events during freeze are discarded. Debouncers keep running, so releases are tracked.
  3. Press event: dir_req<=winner, dir_req_valid<=1. This overwrites any pending unacked request, and wins over a same-cycle ack.
  4. dir_req_ack=1 and dir_req_valid=1: dir_req_valid<=0. dir_req keeps its last value.
  5. Otherwise hold.
- Ack while dir_req_valid=0 is ignored.
- held_dir is registered from the debounced levels with the same priority. It lags db by one edge and is forced to 0000 while freeze=1.
- dir_req is always one-hot or 0000 (0000 only before the first request). held_dir is never multi-hot.

Test Plan:
- Reset: hold rst=1 for 4 cycles with rbtn=1 → all outputs 0. Release rst → dir_req_valid=1, dir_req=0001 exactly 6 edges after deassert (DEBOUNCE_CYCLES=4).
- Clean press: ubtn 0→1 held → dir_req_valid rises at edge 6, dir_req=0100, held_dir=0100 at edge 7. Pulse dir_req_ack → valid=0 next edge. Holding ubtn produces no new request.
- Bounce: lbtn toggles 1,0,1,0 on consecutive cycles, then stays 1 → no request during bouncing. Request 0010 arrives exactly 6 edges after the final stable 1.
- Simultaneous: rbtn and dbtn rise in the same cycle → dir_req=0001 only, held_dir=0001. Release rbtn → held_dir becomes 1000 after 6+1 edges; no new request.
- Overwrite/ack race: pending 0100 unacked, then an lbtn press event edge coincides with dir_req_ack=1 → valid stays 1, dir_req=0010.
- Freeze: freeze=1, press dbtn → valid stays 0, held_dir=0000. Drop freeze while dbtn is still held → no request and held_dir=1000. Release and re-press dbtn → request 1000.
